// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the IF->ID fetch queue: default widths, the bubble
// encoding and the packed entry layout {pc, pc_plus_4, instr}.
package fetch_queue_pkg;

    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;

    // Downstream hazard logic treats an all-zero instruction as a flushed slot.
    localparam logic [31:0] BUBBLE_INSTR = 32'b0;

    function automatic int fq_entry_w(input int xlen, input int ilen);
        return 2 * xlen + ilen;
    endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for the fetch queue: one synchronous write port, one
// asynchronous read port, contents deliberately left unreset.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int W     = fq_entry_w(XLEN_DEF, ILEN_DEF),
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch queue between ifu and idu with valid/ready on both sides,
// single-cycle flush, saturating flush-drop counter and optional empty bypass.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ILEN   = ILEN_DEF,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [XLEN-1:0]          enq_pc_plus_4,
    input  logic [ILEN-1:0]          enq_instr,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_pc_plus_4,
    output logic [ILEN-1:0]          deq_instr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         flush_drops
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = fq_entry_w(XLEN, ILEN);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CW-1:0]    b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_drops;

    logic          w_empty;
    logic          w_full;
    logic          w_byp;
    logic          w_deq_valid;
    logic [EW-1:0] w_enq_entry;
    logic [EW-1:0] w_rdata;
    logic [EW-1:0] w_deq_entry;
    logic          w_enq_fire;
    logic          w_deq_fire;
    logic          w_pass;
    logic          w_we;
    logic          w_rd_adv;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_byp       = (BYPASS != 0) && w_empty;
    assign w_enq_entry = {enq_pc, enq_pc_plus_4, enq_instr};

    // enq_ready deliberately ignores deq_ready: no deq->enq combinational path.
    assign enq_ready = !w_full && !flush;

    always_comb begin
        w_deq_valid = 1'b0;
        w_deq_entry = {{(2 * XLEN){1'b0}}, ILEN'(BUBBLE_INSTR)};
        if (!flush) begin
            if (!w_empty) begin
                w_deq_valid = 1'b1;
                w_deq_entry = w_rdata;
            end else if (w_byp && enq_valid) begin
                w_deq_valid = 1'b1;
                w_deq_entry = w_enq_entry;
            end
        end
    end

    assign w_enq_fire = enq_valid && enq_ready;
    assign w_deq_fire = w_deq_valid && deq_ready;
    // An entry consumed straight through the bypass is never written.
    assign w_pass     = w_empty && w_deq_fire;
    assign w_we       = w_enq_fire && !w_pass;
    assign w_rd_adv   = w_deq_fire && !w_empty;

    fq_storage #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (sys_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_enq_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drops  <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
            r_drops  <= sat_add(r_drops, r_count);
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_we, w_rd_adv})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign deq_valid     = w_deq_valid;
    assign deq_pc        = w_deq_entry[EW-1 -: XLEN];
    assign deq_pc_plus_4 = w_deq_entry[ILEN +: XLEN];
    assign deq_instr     = w_deq_entry[ILEN-1:0];
    assign count         = r_count;
    assign flush_drops   = r_drops;

endmodule
